serial_div_unit: RTL and testbench

- Iterative radix-2 integer divider.
- Sits directly downstream of the serial arithmetic reservation station. It receives one instruction at a time through the EU handshake and returns its result, tagged with the instruction's ROB index, through the EU result handshake.
- Implements the RV64M DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW operations.
- Computes one quotient bit per cycle.

---
 rtl/serial_div_unit.sv | 203 ++++++++++++++++++++
 tb/tb_serial_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_div_unit.sv
`default_nettype none
// ============================================================================
// serial_div_unit: iterative radix-2 RV64M divider (one quotient bit/cycle)
// Revision: 1.0
// ============================================================================

package len5_pkg;
  localparam int unsigned XLEN = 64;
  typedef logic [5:0] except_code_t;
endpackage

package expipe_pkg;
  localparam int unsigned ROB_IDX_LEN = 4;
  typedef logic [ROB_IDX_LEN-1:0] rob_idx_t;
endpackage

module serial_div_unit #(
  parameter int unsigned EU_CTL_LEN = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [EU_CTL_LEN-1:0]     ctl_i,
  input  logic [len5_pkg::XLEN-1:0] rs1_i,
  input  logic [len5_pkg::XLEN-1:0] rs2_i,
  input  expipe_pkg::rob_idx_t      rob_idx_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output expipe_pkg::rob_idx_t      rob_idx_o,
  output logic [len5_pkg::XLEN-1:0] result_o,
  output logic                      except_raised_o,
  output len5_pkg::except_code_t    except_code_o
);

  localparam int unsigned XLEN = len5_pkg::XLEN;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [6:0] CNT_WORD = 7'd32;
  localparam logic [6:0] CNT_DBL  = 7'd64;

  logic [1:0]           state_q, state_d;
  logic [6:0]           cnt_q, cnt_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 sel_rem_q, sel_rem_d;
  logic                 word_q, word_d;
  expipe_pkg::rob_idx_t rob_q, rob_d;

  logic            op_uns, op_rem, op_word;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, ovf_min;
  logic            a_neg, b_neg, div_zero, ovf;
  logic            unused_ctl;

  logic [XLEN:0]   step_shift, step_diff;
  logic            step_ge;
  logic [XLEN-1:0] sel_val, fixed_val, res_val;
  logic            sel_neg;

  assign op_uns     = ctl_i[0];
  assign op_rem     = ctl_i[1];
  assign op_word    = ctl_i[2];
  assign unused_ctl = ^ctl_i[EU_CTL_LEN-1:3];

  assign a_ext = op_word ? (op_uns ? {{(XLEN-32){1'b0}}, rs1_i[31:0]}
                                   : {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]}) : rs1_i;
  assign b_ext = op_word ? (op_uns ? {{(XLEN-32){1'b0}}, rs2_i[31:0]}
                                   : {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]}) : rs2_i;

  assign a_neg = ~op_uns & a_ext[XLEN-1];
  assign b_neg = ~op_uns & b_ext[XLEN-1];
  assign a_abs = a_neg ? -a_ext : a_ext;
  assign b_abs = b_neg ? -b_ext : b_ext;

  // Most-negative value at the operating width, as seen after extension
  assign ovf_min  = op_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign ovf      = ~op_uns & (a_ext == ovf_min) & (b_ext == '1);

  assign step_shift = {rem_q, quo_q[XLEN-1]};
  assign step_diff  = step_shift - {1'b0, dvs_q};
  assign step_ge    = ~step_diff[XLEN];

  assign sel_val   = sel_rem_q ? rem_q : quo_q;
  assign sel_neg   = sel_rem_q ? neg_rem_q : neg_quo_q;
  assign fixed_val = sel_neg ? -sel_val : sel_val;
  assign res_val   = word_q ? {{(XLEN-32){fixed_val[31]}}, fixed_val[31:0]} : fixed_val;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = LOAD;
      LOAD:    state_d = (div_zero || ovf) ? DONE : BUSY;
      BUSY:    if (cnt_q == 7'd1) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    result_o = '0;
    case (state_q)
      IDLE: ready_o = 1'b1;
      DONE: begin
        valid_o  = 1'b1;
        result_o = res_val;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    word_d    = word_q;
    rob_d     = rob_q;
    case (state_q)
      LOAD: begin
        rob_d     = rob_idx_i;
        word_d    = op_word;
        sel_rem_d = op_rem;
        cnt_d     = op_word ? CNT_WORD : CNT_DBL;
        if (div_zero) begin
          quo_d     = '1;
          rem_d     = a_ext;
          dvs_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end else if (ovf) begin
          quo_d     = a_ext;
          rem_d     = '0;
          dvs_d     = '0;
          neg_quo_d = 1'b0;
          neg_rem_d = 1'b0;
        end else begin
          // Word dividends sit in the top half so 32 shifts consume them
          quo_d     = op_word ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
          rem_d     = '0;
          dvs_d     = b_abs;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
        end
      end
      BUSY: begin
        rem_d = step_ge ? step_diff[XLEN-1:0] : step_shift[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], step_ge};
        cnt_d = cnt_q - 7'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      word_q    <= 1'b0;
      rob_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      word_q    <= word_d;
      rob_q     <= rob_d;
    end
  end

  assign rob_idx_o       = rob_q;
  assign except_raised_o = 1'b0;
  assign except_code_o   = '0;

endmodule

`default_nettype wire

// File: tb/tb_serial_div_unit.sv
`default_nettype none
// ============================================================================
// tb_serial_div_unit: table-driven bench with result scoreboard
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps

module tb_serial_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n, flush, vin, rdy_o, vout, rdy_in, exc;
  logic [3:0]                ctl;
  logic [63:0]               rs1, rs2, res;
  expipe_pkg::rob_idx_t      idx_i, idx_o;
  len5_pkg::except_code_t    exc_code;

  serial_div_unit #(.EU_CTL_LEN(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .valid_i        (vin),
    .ready_o        (rdy_o),
    .ctl_i          (ctl),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .rob_idx_i      (idx_i),
    .valid_o        (vout),
    .ready_i        (rdy_in),
    .rob_idx_o      (idx_o),
    .result_o       (res),
    .except_raised_o(exc),
    .except_code_o  (exc_code)
  );

  typedef struct {
    logic [3:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  rob;
    int          lat;
    int          acc;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[19];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] idx, input bit push, input logic [63:0] e, input int lat);
    int n = 0;
    while (!rdy_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_ready", 64'(rdy_o), 64'd1);
    ctl = c; rs1 = a; rs2 = b; idx_i = idx; vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
    if (push) sb_q.push_back('{e, idx, lat, cyc});
  endtask

  task automatic wait_result();
    int  n = 0;
    sb_t e;
    while (!vout && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!vout) begin
      n_vec++; n_err++;
      $display("FAIL result_timeout: valid_o low after %0d cycles, required high", n);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      return;
    end
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_result: got result %h, required no result", res);
      return;
    end
    e = sb_q.pop_front();
    chk("result", res, e.res);
    chk("rob_idx", 64'(idx_o), 64'(e.rob));
    chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{4'b0000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[1]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[2]  = '{4'b0001, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[3]  = '{4'b0011, 64'h1234, 64'd0, 64'h1234, 2};
    vecs[4]  = '{4'b0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2};
    vecs[5]  = '{4'b0010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2};
    vecs[6]  = '{4'b0100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[7]  = '{4'b0101, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1_0000_0002, 64'h0000_0000_7FFF_FFFF, 34};
    vecs[8]  = '{4'b0001, 64'd100, 64'd7, 64'd14, 66};
    vecs[9]  = '{4'b0011, 64'd100, 64'd7, 64'd2, 66};
    vecs[10] = '{4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[11] = '{4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[12] = '{4'b0010, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66};
    vecs[13] = '{4'b0111, 64'h1_0000_0005, 64'd3, 64'd2, 34};
    vecs[14] = '{4'b0100, 64'h10, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    vecs[15] = '{4'b0110, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2};
    vecs[16] = '{4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[17] = '{4'b0101, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 34};
    vecs[18] = '{4'b0100, 64'h8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34};

    rst_n = 1'b0; flush = 1'b0; vin = 1'b0; rdy_in = 1'b1;
    ctl = '0; rs1 = '0; rs2 = '0; idx_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_ready", 64'(rdy_o), 64'd1);
    chk("rst_valid", 64'(vout), 64'd0);
    chk("rst_result", res, 64'd0);
    chk("rst_rob", 64'(idx_o), 64'd0);
    chk("except_raised", 64'(exc), 64'd0);
    chk("except_code", 64'(exc_code), 64'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].ctl, vecs[i].a, vecs[i].b, 4'(i + 1), 1'b1, vecs[i].exp, vecs[i].lat);
      wait_result();
    end
    @(posedge clk); #1;
    chk("post_handshake_valid", 64'(vout), 64'd0);

    // Back-pressure: result must hold while ready_i is low
    rdy_in = 1'b0;
    issue(4'b0000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 4'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    wait_result();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(vout), 64'd1);
      chk("bp_result", res, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("bp_rob", 64'(idx_o), 64'd5);
      chk("bp_ready", 64'(rdy_o), 64'd0);
    end
    rdy_in = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(vout), 64'd0);
    chk("bp_release_ready", 64'(rdy_o), 64'd1);

    // Flush while BUSY
    issue(4'b0001, 64'd100, 64'd7, 4'd3, 1'b0, 64'd0, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("busy_ready", 64'(rdy_o), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready", 64'(rdy_o), 64'd1);
    chk("flush_valid", 64'(vout), 64'd0);
    chk("flush_result", res, 64'd0);
    chk("flush_rob", 64'(idx_o), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (vout) seen = 1'b1;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // Flush in the accept cycle cancels acceptance
    ctl = 4'b0011; rs1 = 64'd9; rs2 = 64'd0; idx_i = 4'd7;
    vin = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0; flush = 1'b0;
    chk("flush_accept_ready", 64'(rdy_o), 64'd1);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (vout) seen = 1'b1;
    end
    chk("flush_accept_no_valid", 64'(seen), 64'd0);

    // Reset mid-operation
    issue(4'b0000, 64'd1000, 64'd3, 4'd9, 1'b0, 64'd0, 0);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ready", 64'(rdy_o), 64'd1);
    chk("midrst_valid", 64'(vout), 64'd0);
    chk("midrst_result", res, 64'd0);
    chk("midrst_rob", 64'(idx_o), 64'd0);
    issue(4'b0001, 64'd100, 64'd7, 4'd2, 1'b1, 64'd14, 66);
    wait_result();
    @(posedge clk); #1;

    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
